// File: rtl/keypad_pkg.sv
// keypad_pkg
//   Types and helpers shared by the keypad matrix scanner.
//   - kp_state_e : debounce/repeat FSM states
//   - kp_cnt_t   : saturating per-frame key count (0, 1, or "2 or more")
//   - kp_width() : bit width of an index into n items (at least 1)
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CAND = 2'd1,
    ST_HELD = 2'd2,
    ST_REL  = 2'd3
  } kp_state_e;

  typedef logic [1:0] kp_cnt_t;

  localparam kp_cnt_t CNT_NONE  = 2'd0;
  localparam kp_cnt_t CNT_ONE   = 2'd1;
  localparam kp_cnt_t CNT_MULTI = 2'd2;

  function automatic int kp_width(input int n);
    if (n < 2) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/keypad_col_scan.sv
// keypad_col_scan
//   Column scan timebase. A dwell counter runs 0..SCAN_DIV-1 and then the
//   one-hot column drive rotates left, wrapping the last column to column 0.
// Ports
//   clk         in   system clock
//   reset       in   asynchronous, active-high
//   col_drive   out  one-hot active-high column drive
//   col_idx     out  binary index of the driven column
//   sample_stb  out  high on the last dwell cycle of every column
//   frame_end   out  high on the last dwell cycle of the last column
module keypad_col_scan
  import keypad_pkg::*;
#(
  parameter  int N_COLS   = 4,
  parameter  int SCAN_DIV = 1000,
  localparam int CW       = kp_width(N_COLS)
) (
  input  logic              clk,
  input  logic              reset,
  output logic [N_COLS-1:0] col_drive,
  output logic [CW-1:0]     col_idx,
  output logic              sample_stb,
  output logic              frame_end
);

  localparam int DVW = kp_width(SCAN_DIV);

  logic [DVW-1:0]    dwell_q, dwell_d;
  logic [CW-1:0]     col_idx_q, col_idx_d;
  logic [N_COLS-1:0] col_drive_q, col_drive_d;
  logic              last_dwell;

  always_comb begin
    last_dwell  = (dwell_q == DVW'(SCAN_DIV - 1));
    dwell_d     = dwell_q + DVW'(1);
    col_idx_d   = col_idx_q;
    col_drive_d = col_drive_q;
    if (last_dwell) begin
      dwell_d     = '0;
      col_idx_d   = (col_idx_q == CW'(N_COLS - 1)) ? '0 : col_idx_q + CW'(1);
      col_drive_d = (col_drive_q << 1) | (col_drive_q >> (N_COLS - 1));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dwell_q     <= '0;
      col_idx_q   <= '0;
      col_drive_q <= N_COLS'(1);
    end else begin
      dwell_q     <= dwell_d;
      col_idx_q   <= col_idx_d;
      col_drive_q <= col_drive_d;
    end
  end

  assign col_drive  = col_drive_q;
  assign col_idx    = col_idx_q;
  assign sample_stb = last_dwell;
  assign frame_end  = last_dwell && (col_idx_q == CW'(N_COLS - 1));

endmodule

// File: rtl/keypad_matrix_scanner.sv
// keypad_matrix_scanner
//   Scans a row/column key matrix, debounces one key at a time, rejects
//   multi-key frames and optionally auto-repeats a held key.
// Ports
//   clk        in   system clock
//   reset      in   asynchronous, active-high
//   col_drive  out  one-hot active-high column drive
//   row_sense  in   active-high row returns, asynchronous to clk
//   key_code   out  row*N_COLS+col of the last accepted key
//   key_valid  out  one-cycle pulse per accepted press and per repeat
//   key_held   out  high while the accepted key is debounced-pressed
//   multi_key  out  high after a frame with more than one key pressed
//
// state   | meaning
// --------+---------------------------------------------------------
// ST_IDLE | no key accepted, waiting for a single-key frame
// ST_CAND | single key seen, counting identical frames (dbc)
// ST_HELD | key accepted, counting frames for auto-repeat (rep)
// ST_REL  | accepted key gone, counting empty frames (rdc)
module keypad_matrix_scanner
  import keypad_pkg::*;
#(
  parameter  int N_ROWS          = 4,
  parameter  int N_COLS          = 4,
  parameter  int SCAN_DIV        = 1000,
  parameter  int DEBOUNCE_FRAMES = 4,
  parameter  int REPEAT_FRAMES   = 0,
  localparam int KW              = kp_width(N_ROWS * N_COLS)
) (
  input  logic              clk,
  input  logic              reset,
  output logic [N_COLS-1:0] col_drive,
  input  logic [N_ROWS-1:0] row_sense,
  output logic [KW-1:0]     key_code,
  output logic              key_valid,
  output logic              key_held,
  output logic              multi_key
);

  localparam int NK = N_ROWS * N_COLS;
  localparam int CW = kp_width(N_COLS);
  localparam int DW = kp_width(DEBOUNCE_FRAMES + 1);
  localparam int RW = kp_width(REPEAT_FRAMES + 1);

  logic [CW-1:0] col_idx;
  logic          sample_stb;
  logic          frame_end;

  keypad_col_scan #(
    .N_COLS   (N_COLS),
    .SCAN_DIV (SCAN_DIV)
  ) u_col_scan (
    .clk        (clk),
    .reset      (reset),
    .col_drive  (col_drive),
    .col_idx    (col_idx),
    .sample_stb (sample_stb),
    .frame_end  (frame_end)
  );

  logic [N_ROWS-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic [NK-1:0]     frame_q, frame_d;
  logic              eval_q, eval_d;
  kp_state_e         state_q, state_d;
  logic [DW-1:0]     dbc_q, dbc_d;
  logic [DW-1:0]     rdc_q, rdc_d;
  logic [RW-1:0]     rep_q, rep_d;
  logic [KW-1:0]     cand_q, cand_d;
  logic [KW-1:0]     key_code_q, key_code_d;
  logic              key_valid_q, key_valid_d;
  logic              key_held_q, key_held_d;
  logic              multi_q, multi_d;

  kp_cnt_t           cnt;
  logic [KW-1:0]     code;

  // Every sample overwrites its whole column, so the bitmap needs no clear
  // between frames and is stable during the evaluation cycle.
  always_comb begin
    sync1_d = row_sense;
    sync2_d = sync1_q;
    frame_d = frame_q;
    eval_d  = frame_end;
    if (sample_stb) begin
      for (int c = 0; c < N_COLS; c++) begin
        if (col_idx == CW'(c)) begin
          for (int r = 0; r < N_ROWS; r++) begin
            frame_d[r*N_COLS + c] = sync2_q[r];
          end
        end
      end
    end
  end

  // Saturating key count; code is the lowest set index, only meaningful for one key.
  always_comb begin
    cnt  = CNT_NONE;
    code = '0;
    for (int k = 0; k < NK; k++) begin
      if (frame_q[k]) begin
        if (cnt == CNT_NONE) begin
          cnt  = CNT_ONE;
          code = KW'(k);
        end else begin
          cnt  = CNT_MULTI;
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    dbc_d       = dbc_q;
    rdc_d       = rdc_q;
    rep_d       = rep_q;
    cand_d      = cand_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    multi_d     = multi_q;

    if (eval_q) begin
      if (cnt == CNT_MULTI)     multi_d = 1'b1;
      else if (cnt == CNT_NONE) multi_d = 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (cnt == CNT_ONE) begin
            if (DEBOUNCE_FRAMES <= 1) begin
              state_d     = ST_HELD;
              key_code_d  = code;
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
              rep_d       = '0;
            end else begin
              state_d = ST_CAND;
              dbc_d   = DW'(1);
              cand_d  = code;
            end
          end
        end

        ST_CAND: begin
          if (cnt == CNT_ONE && code == cand_q) begin
            if (int'(dbc_q) + 1 >= DEBOUNCE_FRAMES) begin
              state_d     = ST_HELD;
              key_code_d  = cand_q;
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
              rep_d       = '0;
            end else begin
              dbc_d = dbc_q + DW'(1);
            end
          end else if (cnt == CNT_ONE) begin
            dbc_d  = DW'(1);
            cand_d = code;
          end else begin
            state_d = ST_IDLE;
          end
        end

        ST_HELD: begin
          if (cnt == CNT_ONE && code == key_code_q) begin
            if (REPEAT_FRAMES > 0) begin
              if (int'(rep_q) + 1 >= REPEAT_FRAMES) begin
                rep_d       = '0;
                key_valid_d = 1'b1;
              end else begin
                rep_d = rep_q + RW'(1);
              end
            end
          end else if (cnt == CNT_NONE && DEBOUNCE_FRAMES <= 1) begin
            state_d    = ST_IDLE;
            key_held_d = 1'b0;
          end else begin
            state_d = ST_REL;
            rdc_d   = DW'(1);
          end
        end

        ST_REL: begin
          if (cnt == CNT_NONE) begin
            if (int'(rdc_q) + 1 >= DEBOUNCE_FRAMES) begin
              state_d    = ST_IDLE;
              key_held_d = 1'b0;
            end else begin
              rdc_d = rdc_q + DW'(1);
            end
          end else if (cnt == CNT_ONE && code == key_code_q) begin
            // Contact bounce on release: resume holding without a new press.
            state_d = ST_HELD;
            rep_d   = '0;
          end else begin
            rdc_d = DW'(1);
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      frame_q     <= '0;
      eval_q      <= 1'b0;
      state_q     <= ST_IDLE;
      dbc_q       <= '0;
      rdc_q       <= '0;
      rep_q       <= '0;
      cand_q      <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
      multi_q     <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      frame_q     <= frame_d;
      eval_q      <= eval_d;
      state_q     <= state_d;
      dbc_q       <= dbc_d;
      rdc_q       <= rdc_d;
      rep_q       <= rep_d;
      cand_q      <= cand_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
      multi_q     <= multi_d;
    end
  end

  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;
  assign multi_key = multi_q;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Bench for keypad_matrix_scanner: 4x4 matrix, SCAN_DIV=4, DEBOUNCE_FRAMES=3.
// Two instances share the stimulus: dut_a without repeat, dut_b with REPEAT_FRAMES=5.
module tb_keypad_matrix_scanner;

  localparam int DB = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] pressed = '0;

  logic [3:0] col_a, col_b, row_a, row_b, code_a, code_b;
  logic       kv_a, kv_b, kh_a, kh_b, mk_a, mk_b;

  always #5 clk = ~clk;

  // Bit r*4+c of 'pressed' closes the switch between row r and column c.
  always_comb begin
    row_a = '0;
    row_b = '0;
    for (int r = 0; r < 4; r++) begin
      row_a[r] = |(pressed[r*4 +: 4] & col_a);
      row_b[r] = |(pressed[r*4 +: 4] & col_b);
    end
  end

  keypad_matrix_scanner #(
    .N_ROWS(4), .N_COLS(4), .SCAN_DIV(4), .DEBOUNCE_FRAMES(DB), .REPEAT_FRAMES(0)
  ) dut_a (
    .clk(clk), .reset(reset), .col_drive(col_a), .row_sense(row_a),
    .key_code(code_a), .key_valid(kv_a), .key_held(kh_a), .multi_key(mk_a)
  );

  keypad_matrix_scanner #(
    .N_ROWS(4), .N_COLS(4), .SCAN_DIV(4), .DEBOUNCE_FRAMES(DB), .REPEAT_FRAMES(5)
  ) dut_b (
    .clk(clk), .reset(reset), .col_drive(col_b), .row_sense(row_b),
    .key_code(code_b), .key_valid(kv_b), .key_held(kh_b), .multi_key(mk_b)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model, one frame at a time, in terms of streaks of identical frames.
  int rpt       [2] = '{0, 5};
  int m_held    [2];
  int m_relg    [2];
  int m_relcnt  [2];
  int m_strk    [2];
  int m_scode   [2];
  int m_code    [2];
  int m_since   [2];
  int m_multi   [2];
  int m_pulse   [2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_held[i] = 0; m_relg[i] = 0; m_relcnt[i] = 0; m_strk[i] = 0;
      m_scode[i] = 0; m_code[i] = 0; m_since[i] = 0; m_multi[i] = 0; m_pulse[i] = 0;
    end
  endtask

  task automatic model_frame(input logic [15:0] m);
    int n, code;
    n = 0;
    code = 0;
    for (int k = 0; k < 16; k++) if (m[k]) begin
      if (n == 0) code = k;
      n++;
    end
    for (int i = 0; i < 2; i++) begin
      m_pulse[i] = 0;
      if (n >= 2) m_multi[i] = 1;
      else if (n == 0) m_multi[i] = 0;
      if (m_held[i] == 0) begin
        if (n == 1) begin
          if (m_strk[i] > 0 && code == m_scode[i]) m_strk[i]++;
          else begin m_strk[i] = 1; m_scode[i] = code; end
          if (m_strk[i] >= DB) begin
            m_held[i] = 1; m_relg[i] = 0; m_code[i] = code;
            m_pulse[i] = 1; m_since[i] = 0; m_strk[i] = 0;
          end
        end else m_strk[i] = 0;
      end else if (m_relg[i] == 0) begin
        if (n == 1 && code == m_code[i]) begin
          m_since[i]++;
          if (rpt[i] > 0 && m_since[i] == rpt[i]) begin m_pulse[i] = 1; m_since[i] = 0; end
        end else begin
          m_relg[i] = 1; m_relcnt[i] = 1;
        end
      end else begin
        if (n == 0) begin
          m_relcnt[i]++;
          if (m_relcnt[i] >= DB) begin m_held[i] = 0; m_relg[i] = 0; end
        end else if (n == 1 && code == m_code[i]) begin
          m_relg[i] = 0; m_since[i] = 0;
        end else m_relcnt[i] = 1;
      end
    end
  endtask

  // Outputs seen one cycle after the end of the previous frame.
  int obs_v [2], obs_h [2], obs_c [2], obs_m [2];

  // Applies one frame (16 clk) aligned to the scan, checking both instances
  // against the model every cycle, then advances the model.
  task automatic run_frame(input logic [15:0] m);
    pressed = m;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      chk("col_drive_a", col_a, 1 << (((i + 1) % 16) / 4));
      chk("col_drive_b", col_b, 1 << (((i + 1) % 16) / 4));
      chk("key_valid_a", kv_a, (i == 0) ? m_pulse[0] : 0);
      chk("key_valid_b", kv_b, (i == 0) ? m_pulse[1] : 0);
      if (i == 0) begin
        chk("key_held_a", kh_a, m_held[0]);
        chk("key_held_b", kh_b, m_held[1]);
        chk("key_code_a", code_a, m_code[0]);
        chk("key_code_b", code_b, m_code[1]);
        chk("multi_key_a", mk_a, m_multi[0]);
        chk("multi_key_b", mk_b, m_multi[1]);
        obs_v[0] = kv_a; obs_h[0] = kh_a; obs_c[0] = code_a; obs_m[0] = mk_a;
        obs_v[1] = kv_b; obs_h[1] = kh_b; obs_c[1] = code_b; obs_m[1] = mk_b;
      end
    end
    model_frame(m);
  endtask

  // Reset asserted at an arbitrary point of a frame, released 1 ns after a rising edge.
  task automatic do_reset();
    pressed = '0;
    repeat ($urandom_range(1, 13)) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("rst_col_a", col_a, 4'b0001);
    chk("rst_col_b", col_b, 4'b0001);
    chk("rst_outs_a", {code_a, kv_a, kh_a, mk_a}, 0);
    chk("rst_outs_b", {code_b, kv_b, kh_b, mk_b}, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic [15:0] mask;
    int v;
    int h;
    int c;
    int m;
  } vec_t;

  vec_t tbl [37];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [15:0] m;
    int kind, len, k1, k2, frames;

    // {mask for the frame, expected key_valid/key_held/key_code/multi_key after it}
    tbl = '{
      '{16'h0040, 0, 0, 0, 0}, '{16'h0040, 0, 0, 0, 0}, '{16'h0040, 1, 1, 6, 0},
      '{16'h0040, 0, 1, 6, 0}, '{16'h0000, 0, 1, 6, 0}, '{16'h0000, 0, 1, 6, 0},
      '{16'h0040, 0, 1, 6, 0}, '{16'h0000, 0, 1, 6, 0}, '{16'h0000, 0, 1, 6, 0},
      '{16'h0000, 0, 0, 6, 0}, '{16'h0040, 0, 0, 6, 0}, '{16'h0040, 0, 0, 6, 0},
      '{16'h0000, 0, 0, 6, 0}, '{16'h0040, 0, 0, 6, 0}, '{16'h0040, 0, 0, 6, 0},
      '{16'h0040, 1, 1, 6, 0}, '{16'h0000, 0, 1, 6, 0}, '{16'h0000, 0, 1, 6, 0},
      '{16'h0000, 0, 0, 6, 0}, '{16'h2002, 0, 0, 6, 1}, '{16'h2002, 0, 0, 6, 1},
      '{16'h0000, 0, 0, 6, 0}, '{16'h0001, 0, 0, 6, 0}, '{16'h0001, 0, 0, 6, 0},
      '{16'h0001, 1, 1, 0, 0}, '{16'h0003, 0, 1, 0, 1}, '{16'h0000, 0, 1, 0, 0},
      '{16'h0000, 0, 0, 0, 0}, '{16'h0000, 0, 0, 0, 0}, '{16'h0020, 0, 0, 0, 0},
      '{16'h0020, 0, 0, 0, 0}, '{16'h0020, 1, 1, 5, 0}, '{16'h0040, 0, 1, 5, 0},
      '{16'h0000, 0, 1, 5, 0}, '{16'h0040, 0, 1, 5, 0}, '{16'h0000, 0, 1, 5, 0},
      '{16'h0000, 0, 0, 5, 0}
    };

    model_reset();
    do_reset();

    // Directed table against the non-repeating instance.
    for (int j = 0; j <= 37; j++) begin
      run_frame((j < 37) ? tbl[j].mask : 16'h0000);
      if (j > 0) begin
        chk("tbl_valid", obs_v[0], tbl[j-1].v);
        chk("tbl_held",  obs_h[0], tbl[j-1].h);
        chk("tbl_code",  obs_c[0], tbl[j-1].c);
        chk("tbl_multi", obs_m[0], tbl[j-1].m);
      end
    end

    // Auto-repeat: key 0 held for frames 0..19, then released.
    do_reset();
    for (int f = 0; f < 24; f++) begin
      run_frame((f < 20) ? 16'h0001 : 16'h0000);
      if (f > 0) begin
        chk("rep_pulse", obs_v[1],
            ((f - 1) == 2 || (f - 1) == 7 || (f - 1) == 12 || (f - 1) == 17) ? 1 : 0);
        chk("norep_pulse", obs_v[0], ((f - 1) == 2) ? 1 : 0);
        if (obs_v[1] != 0) chk("rep_code", obs_c[1], 0);
      end
    end

    // Random runs of single keys, empty frames and key pairs.
    do_reset();
    frames = 0;
    while (frames < 170) begin
      kind = $urandom_range(0, 3);
      len  = $urandom_range(1, 6);
      k1   = $urandom_range(0, 15);
      k2   = (k1 + $urandom_range(1, 15)) % 16;
      m    = '0;
      if (kind == 1 || kind == 2) m[k1] = 1'b1;
      if (kind == 3) begin m[k1] = 1'b1; m[k2] = 1'b1; end
      for (int r = 0; r < len; r++) begin
        run_frame(m);
        frames++;
      end
    end
    run_frame(16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
